// File: rtl/c2_multi_arbiter.sv
// UART command arbiter: decodes a command byte, acknowledges it, grants the UART TX
// path to one client session, and supervises the session with a watchdog and cleanup.
module c2_multi_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int NUM_CMDS = 6,
  parameter int DATA_W = 8,
  parameter logic [NUM_CMDS*DATA_W-1:0] CMD_CODES = {8'hA1, 8'hA0, 8'hDE, 8'hCE, 8'h1D, 8'h1C},
  parameter logic [NUM_CMDS*8-1:0] CMD_CLIENT = {8'd3, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0},
  parameter logic [NUM_CMDS-1:0] CMD_MODE = 6'b000101,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int RECOVERY_CYCLES = 2,
  parameter bit NAK_EN = 1'b1,
  parameter logic [DATA_W-1:0] NAK_BYTE = 8'h15,
  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_W-1:0]             uart_rx_data_i,
  input  logic                          uart_rx_ready_i,
  output logic [DATA_W-1:0]             uart_tx_data_o,
  output logic                          uart_tx_start_o,
  input  logic                          uart_tx_done_i,
  output logic [NUM_CLIENTS-1:0]        grant_o,
  output logic                          mode_o,
  output logic [CW-1:0]                 active_client_o,
  input  logic [NUM_CLIENTS-1:0]        client_done_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_tx_data_i,
  input  logic [NUM_CLIENTS-1:0]        client_tx_start_i,
  output logic                          soft_reset_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  typedef enum logic [2:0] {
    IDLE, ACK_SEND, ACK_WAIT, GRANTED, NAK_SEND, NAK_WAIT, CLEANUP, RECOVERY
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WD_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RC_W = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

  state_t state_reg, state_next;
  logic [DATA_W-1:0] cmd_byte_reg, cmd_byte_next;
  logic [CW-1:0] client_reg, client_next;
  logic mode_reg, mode_next;
  logic abort_reg, abort_next;
  logic [WD_W-1:0] wd_cnt_reg;
  logic [RC_W-1:0] rc_cnt_reg;

  logic [NUM_CMDS-1:0] cmd_match;
  logic hit;
  logic [CW-1:0] hit_client;
  logic hit_mode;
  logic [NUM_CLIENTS-1:0] grant_vec;
  logic [DATA_W-1:0] client_data_masked [NUM_CLIENTS];
  logic [DATA_W-1:0] client_data_sel;
  logic client_start_sel;
  logic client_done_sel;
  logic wd_expired;
  logic timeout_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CMDS; gi++) begin : g_match
      assign cmd_match[gi] = (uart_rx_data_i == CMD_CODES[gi*DATA_W +: DATA_W]);
    end
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign grant_vec[gi] = (state_reg == GRANTED) && (client_reg == CW'(gi));
      assign client_data_masked[gi] =
        client_tx_data_i[gi*DATA_W +: DATA_W] & {DATA_W{grant_vec[gi]}};
    end
  endgenerate

  // Scan from the top so the lowest matching table entry is the one that sticks.
  always_comb begin
    hit = 1'b0;
    hit_client = '0;
    hit_mode = 1'b0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (cmd_match[i]) begin
        hit = 1'b1;
        hit_client = CW'(CMD_CLIENT[i*8 +: 8]);
        hit_mode = CMD_MODE[i];
      end
    end
  end

  always_comb begin
    client_data_sel = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      client_data_sel = client_data_sel | client_data_masked[k];
    end
  end

  assign client_start_sel = |(client_tx_start_i & grant_vec);
  assign client_done_sel = |(client_done_i & grant_vec);
  assign wd_expired = WD_EN && (wd_cnt_reg == WD_LIMIT);

  always_comb begin
    state_next = state_reg;
    cmd_byte_next = cmd_byte_reg;
    client_next = client_reg;
    mode_next = mode_reg;
    abort_next = abort_reg;
    timeout_pulse = 1'b0;
    case (state_reg)
      IDLE: begin
        if (uart_rx_ready_i) begin
          if (hit) begin
            cmd_byte_next = uart_rx_data_i;
            client_next = hit_client;
            mode_next = hit_mode;
            state_next = ACK_SEND;
          end else if (NAK_EN) begin
            abort_next = 1'b0;
            state_next = NAK_SEND;
          end
        end
      end
      ACK_SEND: state_next = ACK_WAIT;
      ACK_WAIT: begin
        if (uart_tx_done_i) begin
          state_next = GRANTED;
        end else if (wd_expired) begin
          timeout_pulse = 1'b1;
          state_next = CLEANUP;
        end
      end
      GRANTED: begin
        // A session that finishes on the expiry cycle counts as a clean finish.
        if (client_done_sel) begin
          state_next = CLEANUP;
        end else if (wd_expired) begin
          timeout_pulse = 1'b1;
          abort_next = 1'b1;
          state_next = NAK_SEND;
        end
      end
      NAK_SEND: state_next = NAK_WAIT;
      NAK_WAIT: begin
        if (uart_tx_done_i) begin
          state_next = abort_reg ? CLEANUP : IDLE;
        end
      end
      CLEANUP: state_next = (RECOVERY_CYCLES > 0) ? RECOVERY : IDLE;
      RECOVERY: begin
        if (rc_cnt_reg == RC_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    uart_tx_start_o = 1'b0;
    uart_tx_data_o = '0;
    case (state_reg)
      ACK_SEND: begin
        uart_tx_start_o = 1'b1;
        uart_tx_data_o = cmd_byte_reg;
      end
      NAK_SEND: begin
        uart_tx_start_o = 1'b1;
        uart_tx_data_o = NAK_BYTE;
      end
      GRANTED: begin
        uart_tx_start_o = client_start_sel;
        uart_tx_data_o = client_data_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cmd_byte_reg <= '0;
      client_reg <= '0;
      mode_reg <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cmd_byte_reg <= cmd_byte_next;
      client_reg <= client_next;
      mode_reg <= mode_next;
      abort_reg <= abort_next;
    end
  end

  // Watchdog restarts on entering a supervised state and on every granted TX strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_reg <= '0;
    end else if ((state_next != state_reg) &&
                 ((state_next == ACK_WAIT) || (state_next == GRANTED))) begin
      wd_cnt_reg <= '0;
    end else if ((state_reg == GRANTED) && client_start_sel) begin
      wd_cnt_reg <= '0;
    end else if (((state_reg == ACK_WAIT) || (state_reg == GRANTED)) && !wd_expired) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rc_cnt_reg <= '0;
    end else if (state_reg != RECOVERY) begin
      rc_cnt_reg <= '0;
    end else begin
      rc_cnt_reg <= rc_cnt_reg + 1'b1;
    end
  end

  assign grant_o = grant_vec;
  assign mode_o = mode_reg;
  assign active_client_o = client_reg;
  assign soft_reset_o = (state_reg == CLEANUP);
  assign busy_o = (state_reg != IDLE);
  assign timeout_o = timeout_pulse;

endmodule

// File: tb/tb_c2_multi_arbiter.sv
// Directed bench for c2_multi_arbiter: command decode, ACK/NAK, grant isolation,
// watchdog expiry in both supervised states, cleanup timing and asynchronous reset.
module tb_c2_multi_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready = 1'b0;
  logic tx_done = 1'b0;
  logic [3:0] client_done = '0;
  logic [31:0] client_tx_data = '0;
  logic [3:0] client_tx_start = '0;

  logic [7:0] tx_data;
  logic tx_start;
  logic [3:0] grant;
  logic mode;
  logic [1:0] active;
  logic soft_reset, busy, timeout;

  logic [7:0] n_tx_data;
  logic n_tx_start;
  logic [3:0] n_grant;
  logic n_mode;
  logic [1:0] n_active;
  logic n_soft_reset, n_busy, n_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Debug commands 0xCE/0xDE carry mode=1; the load and client commands carry mode=0.
  c2_multi_arbiter #(
    .CMD_MODE(6'b001100),
    .TIMEOUT_CYCLES(20),
    .NAK_EN(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .uart_rx_data_i(rx_data), .uart_rx_ready_i(rx_ready),
    .uart_tx_data_o(tx_data), .uart_tx_start_o(tx_start), .uart_tx_done_i(tx_done),
    .grant_o(grant), .mode_o(mode), .active_client_o(active),
    .client_done_i(client_done), .client_tx_data_i(client_tx_data),
    .client_tx_start_i(client_tx_start),
    .soft_reset_o(soft_reset), .busy_o(busy), .timeout_o(timeout)
  );

  c2_multi_arbiter #(
    .NAK_EN(1'b0)
  ) u_nonak (
    .clk_i(clk), .rst_ni(rst_n),
    .uart_rx_data_i(rx_data), .uart_rx_ready_i(rx_ready),
    .uart_tx_data_o(n_tx_data), .uart_tx_start_o(n_tx_start), .uart_tx_done_i(tx_done),
    .grant_o(n_grant), .mode_o(n_mode), .active_client_o(n_active),
    .client_done_i(client_done), .client_tx_data_i(client_tx_data),
    .client_tx_start_i(client_tx_start),
    .soft_reset_o(n_soft_reset), .busy_o(n_busy), .timeout_o(n_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int early;
    int seen;

    // Reset state
    tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_soft_reset", 32'(soft_reset), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_mode_active", {30'd0, mode, active[0]}, 0);
    rst_n = 1'b1;
    tick();
    $display("step reset: busy=%0b grant=%0h", busy, grant);

    // Garbage byte: NAK on one instance, ignored on the other
    send_cmd(8'hFF);
    check("garb_nak_start", 32'(tx_start), 1);
    check("garb_nak_data", 32'(tx_data), 32'h15);
    check("garb_nonak_busy", 32'(n_busy), 0);
    check("garb_nonak_tx", {23'd0, n_tx_start, n_tx_data}, 0);
    check("garb_nonak_grant", 32'(n_grant), 0);
    tick();
    check("garb_nakwait_start", 32'(tx_start), 0);
    check("garb_nakwait_busy", 32'(busy), 1);
    pulse_tx_done();
    check("garb_idle", 32'(busy), 0);
    check("garb_no_soft_reset", 32'(soft_reset), 0);
    $display("step garbage 0xFF: nak sent, busy=%0b", busy);

    // Load command 0x1C for client0
    send_cmd(8'h1C);
    check("load_ack_start", 32'(tx_start), 1);
    check("load_ack_data", 32'(tx_data), 32'h1C);
    check("load_ack_grant", 32'(grant), 0);
    check("load_mode", 32'(mode), 0);
    check("load_active", 32'(active), 0);
    tick();
    check("load_ackwait_start", 32'(tx_start), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("load_ackwait_grant", 32'(grant), 0);
    end
    pulse_tx_done();
    check("load_grant", 32'(grant), 32'h1);
    client_tx_data[7:0] = 8'hF1;
    client_tx_start[0] = 1'b1;
    #1;
    check("load_pass_start", 32'(tx_start), 1);
    check("load_pass_data", 32'(tx_data), 32'hF1);
    client_tx_start = '0;
    client_done[0] = 1'b1;
    tick();
    client_done = '0;
    check("load_cleanup_soft", 32'(soft_reset), 1);
    check("load_cleanup_grant", 32'(grant), 0);
    tick();
    check("load_rec1_soft", 32'(soft_reset), 0);
    check("load_rec1_busy", 32'(busy), 1);
    tick();
    check("load_rec2_busy", 32'(busy), 1);
    tick();
    check("load_idle", 32'(busy), 0);
    client_tx_data = '0;
    $display("step load 0x1C: session complete, busy=%0b", busy);

    // Debug command 0xCE for client1, then isolation and reset mid-session
    send_cmd(8'hCE);
    check("dbg_mode", 32'(mode), 1);
    check("dbg_active", 32'(active), 1);
    check("dbg_ack_grant", 32'(grant), 0);
    check("dbg_ack_data", 32'(tx_data), 32'hCE);
    tick();
    check("dbg_ackwait_grant", 32'(grant), 0);
    pulse_tx_done();
    check("dbg_grant", 32'(grant), 32'h2);
    client_tx_data[7:0] = 8'hAA;
    client_tx_start[0] = 1'b1;
    client_done[0] = 1'b1;
    rx_data = 8'h1C;
    rx_ready = 1'b1;
    #1;
    check("iso_tx_start", 32'(tx_start), 0);
    check("iso_tx_data", 32'(tx_data), 0);
    tick();
    check("iso_grant_held", 32'(grant), 32'h2);
    check("iso_rx_ignored", {30'd0, mode, soft_reset}, 32'h2);
    client_tx_start = '0;
    client_done = '0;
    rx_ready = 1'b0;
    client_tx_data = '0;
    rst_n = 1'b0;
    #1;
    check("rstmid_grant", 32'(grant), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_tx", {23'd0, tx_start, tx_data}, 0);
    check("rstmid_mode_active", {30'd0, mode, active[0]}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("step debug 0xCE: isolation held, reset cleared session");

    // Watchdog in GRANTED: client2, no activity
    send_cmd(8'hA0);
    tick();
    pulse_tx_done();
    check("wd_grant", 32'(grant), 32'h4);
    early = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (timeout) early = 1;
    end
    check("wd_no_early_timeout", 32'(early), 0);
    tick();
    check("wd_timeout_pulse", 32'(timeout), 1);
    tick();
    check("wd_timeout_one_cycle", 32'(timeout), 0);
    check("wd_grant_dropped", 32'(grant), 0);
    check("wd_nak", {23'd0, tx_start, tx_data}, 32'h115);
    tick();
    pulse_tx_done();
    check("wd_soft_reset", 32'(soft_reset), 1);
    tick();
    tick();
    tick();
    check("wd_idle", 32'(busy), 0);
    $display("step watchdog idle client2: timeout, nak, cleanup");

    // Watchdog held off by activity every 10 cycles
    send_cmd(8'hA0);
    tick();
    pulse_tx_done();
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      client_tx_start[2] = (i % 10 == 9);
      tick();
      if (timeout) seen = 1;
    end
    client_tx_start = '0;
    check("wd_activity_no_timeout", 32'(seen), 0);
    check("wd_activity_grant", 32'(grant), 32'h4);
    client_done[2] = 1'b1;
    tick();
    client_done = '0;
    tick();
    tick();
    tick();
    check("wd_activity_idle", 32'(busy), 0);
    $display("step watchdog active client2: no timeout");

    // Watchdog in ACK_WAIT: TX never completes
    send_cmd(8'h1D);
    tick();
    early = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (timeout || grant != 0) early = 1;
    end
    check("ackwd_no_early", 32'(early), 0);
    tick();
    check("ackwd_timeout", 32'(timeout), 1);
    tick();
    check("ackwd_cleanup", {30'd0, soft_reset, tx_start}, 32'h2);
    tick();
    tick();
    tick();
    check("ackwd_idle", 32'(busy), 0);
    $display("step ack watchdog 0x1D: timeout then cleanup");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
